// File: rtl/score_bcd_encoder_pkg.sv
// Shared definitions for the score-to-BCD encoder: widths, default limit and FSM encoding.
package score_bcd_encoder_pkg;

    localparam int unsigned SCORE_W           = 27;
    localparam int unsigned DIGITS            = 8;
    localparam int unsigned BCD_W             = 4 * DIGITS;
    localparam int unsigned SCORE_MAX_DEFAULT = 99_999_999;
    localparam int unsigned LAST_ITER         = SCORE_W - 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CONV    = 2'd1,
        PUBLISH = 2'd2
    } state_t;

endpackage

// File: rtl/score_bcd_encoder_dabble.sv
// One double-dabble iteration: add 3 to every BCD nibble >= 5, then shift in the next score bit.
module bcd_dabble_step
    import score_bcd_encoder_pkg::*;
(
    input  logic [BCD_W-1:0] i_acc,
    input  logic             i_bit,
    output logic [BCD_W-1:0] o_acc
);

    logic [BCD_W-1:0] w_adj;

    always_comb begin
        w_adj = i_acc;
        for (int unsigned d = 0; d < DIGITS; d++) begin
            if (i_acc[4*d +: 4] >= 4'd5) begin
                w_adj[4*d +: 4] = i_acc[4*d +: 4] + 4'd3;
            end
        end
        o_acc = {w_adj[BCD_W-2:0], i_bit};
    end

endmodule

// File: rtl/score_bcd_encoder.sv
// Converts a binary score to eight packed BCD digits and strobes a seven-segment driver,
// with a one-deep newest-wins request buffer and an idle-only periodic refresh strobe.
module score_bcd_encoder
    import score_bcd_encoder_pkg::*;
#(
    parameter int unsigned REFRESH_CYCLES = 1_000_000,
    parameter int unsigned SCORE_MAX      = SCORE_MAX_DEFAULT
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic [SCORE_W-1:0] score,
    input  logic               score_valid,
    output logic               busy,
    output logic [BCD_W-1:0]   data,
    output logic               seg_start,
    output logic               ovf
);

    localparam int unsigned        CNT_W    = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(REFRESH_CYCLES - 1);
    localparam logic [SCORE_W-1:0] MAX_V    = SCORE_W'(SCORE_MAX);
    localparam logic [4:0]         ITER_END = 5'(LAST_ITER);

    state_t             r_state;
    logic [4:0]         r_iter;
    logic [SCORE_W-1:0] r_shift;
    logic [BCD_W-1:0]   r_acc;
    logic               r_pend_v;
    logic [SCORE_W-1:0] r_pend_score;
    logic [CNT_W-1:0]   r_refresh;

    logic [BCD_W-1:0]   w_next_acc;
    logic [SCORE_W-1:0] w_src;
    logic [SCORE_W-1:0] w_sat;
    logic               w_over;
    logic               w_wrap;

    bcd_dabble_step u_step (
        .i_acc (r_acc),
        .i_bit (r_shift[SCORE_W-1]),
        .o_acc (w_next_acc)
    );

    // A request arriving during PUBLISH is newer than the buffered one, so it wins.
    assign w_src  = (r_state == PUBLISH && !score_valid) ? r_pend_score : score;
    assign w_over = (w_src > MAX_V);
    assign w_sat  = w_over ? MAX_V : w_src;
    assign w_wrap = (r_refresh == CNT_LAST);

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state      <= IDLE;
            r_iter       <= '0;
            r_shift      <= '0;
            r_acc        <= '0;
            r_pend_v     <= 1'b0;
            r_pend_score <= '0;
            r_refresh    <= '0;
            busy         <= 1'b0;
            data         <= '0;
            seg_start    <= 1'b0;
            ovf          <= 1'b0;
        end else begin
            r_refresh <= w_wrap ? '0 : r_refresh + 1'b1;
            seg_start <= 1'b0;

            case (r_state)
                IDLE: begin
                    busy <= 1'b0;
                    if (w_wrap) begin
                        seg_start <= 1'b1;
                    end
                    if (score_valid) begin
                        r_shift <= w_sat;
                        r_acc   <= '0;
                        r_iter  <= '0;
                        r_state <= CONV;
                        busy    <= 1'b1;
                        if (w_over) begin
                            ovf <= 1'b1;
                        end
                    end
                end

                CONV: begin
                    r_acc   <= w_next_acc;
                    r_shift <= {r_shift[SCORE_W-2:0], 1'b0};
                    r_iter  <= r_iter + 5'd1;
                    if (score_valid) begin
                        r_pend_v     <= 1'b1;
                        r_pend_score <= score;
                    end
                    // Final iteration result goes straight to the output so data and the strobe line up.
                    if (r_iter == ITER_END) begin
                        data      <= w_next_acc;
                        seg_start <= 1'b1;
                        r_state   <= PUBLISH;
                    end
                end

                PUBLISH: begin
                    if (score_valid || r_pend_v) begin
                        r_pend_v <= 1'b0;
                        r_shift  <= w_sat;
                        r_acc    <= '0;
                        r_iter   <= '0;
                        r_state  <= CONV;
                        if (w_over) begin
                            ovf <= 1'b1;
                        end
                    end else begin
                        r_state <= IDLE;
                        busy    <= 1'b0;
                    end
                end

                default: begin
                    r_state <= IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_score_bcd_encoder.sv
// Directed bench: conversion latency, saturation, newest-wins buffering, refresh gating and reset abort.
module tb_score_bcd_encoder;

    logic        clk;
    logic        rstn;
    logic [26:0] score;
    logic        score_valid;
    logic        busy;
    logic [31:0] data;
    logic        seg_start;
    logic        ovf;

    int total = 0;
    int bad   = 0;
    int p;
    int b;

    score_bcd_encoder #(
        .REFRESH_CYCLES (16),
        .SCORE_MAX      (99_999_999)
    ) dut (
        .clk         (clk),
        .rstn        (rstn),
        .score       (score),
        .score_valid (score_valid),
        .busy        (busy),
        .data        (data),
        .seg_start   (seg_start),
        .ovf         (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic run(input int n, output int pulses, output int busy_hi);
        pulses  = 0;
        busy_hi = 0;
        repeat (n) begin
            tick();
            if (seg_start) pulses++;
            if (busy) busy_hi++;
        end
    endtask

    task automatic request(input logic [26:0] v);
        score       = v;
        score_valid = 1'b1;
        tick();
        score_valid = 1'b0;
    endtask

    initial begin
        rstn        = 1'b0;
        score       = '0;
        score_valid = 1'b0;
        repeat (3) tick();
        // R0: refresh counter is 0 here
        check("rst_data", data, 32'h0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_seg", 32'(seg_start), 32'd0);
        check("rst_ovf", 32'(ovf), 32'd0);
        rstn = 1'b1;

        run(15, p, b);
        check("refresh_quiet_1", 32'(p), 32'd0);
        tick();
        check("refresh_first", 32'(seg_start), 32'd1);
        run(15, p, b);
        check("refresh_quiet_2", 32'(p), 32'd0);
        tick();
        check("refresh_second", 32'(seg_start), 32'd1);

        // basic conversion; a refresh wrap falls at t+15 inside CONV
        request(27'd12345678);
        check("basic_busy_t1", 32'(busy), 32'd1);
        run(26, p, b);
        check("basic_no_pulse", 32'(p), 32'd0);
        check("basic_busy_cnt", 32'(b), 32'd26);
        tick();
        check("basic_data", data, 32'h1234_5678);
        check("basic_seg", 32'(seg_start), 32'd1);
        check("basic_busy_t28", 32'(busy), 32'd1);
        tick();
        check("basic_busy_t29", 32'(busy), 32'd0);
        check("basic_seg_t29", 32'(seg_start), 32'd0);
        run(2, p, b);
        check("basic_idle_quiet", 32'(p), 32'd0);
        tick();
        check("basic_idle_refresh", 32'(seg_start), 32'd1);

        // overflow saturates to SCORE_MAX
        request(27'h7FF_FFFF);
        run(26, p, b);
        tick();
        check("ovf_data", data, 32'h9999_9999);
        check("ovf_flag", 32'(ovf), 32'd1);
        tick();

        // zero conversion; ovf stays sticky
        request(27'd0);
        run(26, p, b);
        check("zero_hold", data, 32'h9999_9999);
        tick();
        check("zero_data", data, 32'h0);
        check("zero_ovf_sticky", 32'(ovf), 32'd1);
        tick();

        // requests while busy: 5 at t, 7 at t+3, 9 at t+10
        request(27'd5);
        run(2, p, b);
        request(27'd7);
        run(6, p, b);
        request(27'd9);
        run(16, p, b);
        tick();
        check("pend_data_5", data, 32'h5);
        check("pend_seg_5", 32'(seg_start), 32'd1);
        tick();
        check("pend_busy_t29", 32'(busy), 32'd1);
        check("pend_seg_t29", 32'(seg_start), 32'd0);
        run(26, p, b);
        check("pend_no_pulse", 32'(p), 32'd0);
        check("pend_hold_5", data, 32'h5);
        tick();
        check("pend_data_9", data, 32'h9);
        check("pend_seg_9", 32'(seg_start), 32'd1);
        tick();
        check("pend_idle", 32'(busy), 32'd0);

        // reset at t+10 of a conversion
        request(27'd4321);
        run(9, p, b);
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        check("abort_data", data, 32'h0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_seg", 32'(seg_start), 32'd0);
        check("abort_ovf", 32'(ovf), 32'd0);
        run(15, p, b);
        check("abort_quiet", 32'(p), 32'd0);
        tick();
        check("abort_refresh", 32'(seg_start), 32'd1);
        tick();
        check("abort_no_publish", data, 32'h0);
        check("abort_idle", 32'(busy), 32'd0);

        // boundary value, plus a request arriving during PUBLISH
        request(27'd99_999_999);
        run(26, p, b);
        tick();
        check("max_data", data, 32'h9999_9999);
        check("max_ovf", 32'(ovf), 32'd0);
        check("max_seg", 32'(seg_start), 32'd1);
        request(27'd42);
        check("pub_req_busy", 32'(busy), 32'd1);
        run(26, p, b);
        tick();
        check("pub_req_data", data, 32'h42);
        check("pub_req_seg", 32'(seg_start), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
